// File: rtl/reg_chain_monitor_if.sv
// Observation bundle between a two-stage registered chain and its checker.
// The master side drives the chain signals; the slave side is the monitor.
interface reg_chain_monitor_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  en;
  logic                  clr;
  logic [DATA_WIDTH-1:0] i;
  logic [DATA_WIDTH-1:0] o;
  logic                  err;
  logic                  err_sticky;
  logic [CNT_WIDTH-1:0]  chk_cnt;
  logic [CNT_WIDTH-1:0]  err_cnt;
  logic [DATA_WIDTH-1:0] first_exp;
  logic [DATA_WIDTH-1:0] first_obs;
  logic                  busy;

  modport master (
    output en, clr, i, o,
    input  err, err_sticky, chk_cnt, err_cnt, first_exp, first_obs, busy
  );

  modport slave (
    input  en, clr, i, o,
    output err, err_sticky, chk_cnt, err_cnt, first_exp, first_obs, busy
  );
endinterface

// File: rtl/reg_chain_monitor.sv
// Checker for the chain r0 = i + 1, r1 = (r0 ^ 1) + 1 + r0: predicts the
// output with the same two-cycle latency and flags, counts and captures mismatches.
module reg_chain_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  reg_chain_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME1 = 2'd1,
    PRIME2 = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  cmp;
  logic                  mism;

  // Prediction pipeline runs regardless of en so priming always sees live samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
    end else begin
      a <= mon.i + ONE;
      b <= (a ^ ONE) + ONE + a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmp        = 1'b0;
    mism       = 1'b0;
    case (state)
      IDLE:    if (mon.en) state_next = PRIME1;
      PRIME1:  state_next = PRIME2;
      PRIME2:  state_next = CHECK;
      CHECK:   state_next = CHECK;
      default: state_next = IDLE;
    endcase
    if (!mon.en) state_next = IDLE;
    // A comparison in CHECK still registers on the edge that samples en low.
    cmp  = (state == CHECK);
    mism = cmp && (mon.o != b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon.busy       <= 1'b0;
      mon.err        <= 1'b0;
      mon.err_sticky <= 1'b0;
      mon.chk_cnt    <= '0;
      mon.err_cnt    <= '0;
      mon.first_exp  <= '0;
      mon.first_obs  <= '0;
    end else begin
      mon.busy <= (state_next != IDLE);
      mon.err  <= mism;
      if (mon.clr) begin
        mon.err_sticky <= 1'b0;
        mon.chk_cnt    <= '0;
        mon.err_cnt    <= '0;
        mon.first_exp  <= '0;
        mon.first_obs  <= '0;
      end else if (cmp) begin
        if (mon.chk_cnt != CNT_MAX) mon.chk_cnt <= mon.chk_cnt + CNT_ONE;
        if (mism) begin
          mon.err_sticky <= 1'b1;
          if (mon.err_cnt != CNT_MAX) mon.err_cnt <= mon.err_cnt + CNT_ONE;
          if (!mon.err_sticky) begin
            mon.first_exp <= b;
            mon.first_obs <= mon.o;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_chain_monitor.sv
// Scoreboard bench for reg_chain_monitor: a behavioural chain model predicts every
// cycle's outputs; a narrow-counter second instance exercises saturation.
module tb_reg_chain_monitor;
  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_chain_monitor_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW))  mon ();
  reg_chain_monitor_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW4)) mon4 ();

  reg_chain_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mon(mon)
  );
  reg_chain_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(CW4)) dut4 (
    .clk(clk), .rst(rst), .mon(mon4)
  );

  typedef struct packed {
    logic          err;
    logic          sticky;
    logic [CW-1:0] chk;
    logic [CW-1:0] errc;
    logic [DW-1:0] fe;
    logic [DW-1:0] fo;
    logic          busy;
  } snap_t;

  snap_t sb_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  // Reference model: length of the current enabled run, last two captured inputs.
  int            runlen;
  logic [DW-1:0] prev1, prev2;
  logic [CW-1:0] m_chk, m_errc;
  logic          m_sticky;
  logic [DW-1:0] m_fe, m_fo;

  function automatic logic [DW-1:0] chain_out(input logic [DW-1:0] x);
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
    r0 = x + 8'd1;
    r1 = (r0 ^ 8'h01) + 8'd1 + r0;
    return r1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    runlen   = 0;
    m_chk    = '0;
    m_errc   = '0;
    m_sticky = 1'b0;
    m_fe     = '0;
    m_fo     = '0;
  endtask

  // omode: 0 = matched chain, 1 = o forced to oval, 2 = o randomly wrong
  task automatic drive(input logic en_v, input logic clr_v, input logic [DW-1:0] i_v,
                       input int omode, input logic [DW-1:0] oval);
    logic [DW-1:0] exp_b;
    logic [DW-1:0] o_v;
    logic          cmp;
    logic          mism;
    snap_t         s;
    @(negedge clk);
    exp_b = chain_out(prev2);
    case (omode)
      0:       o_v = exp_b;
      1:       o_v = oval;
      default: o_v = exp_b ^ 8'($urandom_range(1, 255));
    endcase
    mon.en  = en_v;
    mon.clr = clr_v;
    mon.i   = i_v;
    mon.o   = o_v;
    mon4.i  = i_v;
    mon4.o  = ~exp_b;
    cmp  = (runlen >= 3);
    mism = cmp && (o_v != exp_b);
    if (clr_v) begin
      m_chk    = '0;
      m_errc   = '0;
      m_sticky = 1'b0;
      m_fe     = '0;
      m_fo     = '0;
    end else if (cmp) begin
      if (m_chk != '1) m_chk = m_chk + 1'b1;
      if (mism) begin
        if (m_errc != '1) m_errc = m_errc + 1'b1;
        if (!m_sticky) begin
          m_fe = exp_b;
          m_fo = o_v;
        end
        m_sticky = 1'b1;
      end
    end
    runlen = en_v ? ((runlen < 3) ? runlen + 1 : 3) : 0;
    prev2  = prev1;
    prev1  = i_v;
    s = '{mism, m_sticky, m_chk, m_errc, m_fe, m_fo, (runlen != 0)};
    sb_q.push_back(s);
  endtask

  function automatic logic [DW-1:0] rnd8();
    return 8'($urandom);
  endfunction

  // Monitor: one expected snapshot per edge, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        snap_t exp_s;
        snap_t act_s;
        exp_s = sb_q.pop_front();
        act_s = '{mon.err, mon.err_sticky, mon.chk_cnt, mon.err_cnt,
                  mon.first_exp, mon.first_obs, mon.busy};
        n_chk++;
        if (act_s === exp_s) n_pass++;
        else $display("FAIL cycle_outputs @%0t: got err=%b sticky=%b chk=%0d errc=%0d fe=%h fo=%h busy=%b expected err=%b sticky=%b chk=%0d errc=%0d fe=%h fo=%h busy=%b",
                      $time, act_s.err, act_s.sticky, act_s.chk, act_s.errc, act_s.fe, act_s.fo, act_s.busy,
                      exp_s.err, exp_s.sticky, exp_s.chk, exp_s.errc, exp_s.fe, exp_s.fo, exp_s.busy);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    mon.en   = 1'b0;
    mon.clr  = 1'b0;
    mon.i    = '0;
    mon.o    = '0;
    mon4.en  = 1'b1;
    mon4.clr = 1'b0;
    mon4.i   = '0;
    mon4.o   = '0;
    prev1    = '0;
    prev2    = '0;
    model_reset();
    #22 rst = 1'b0;
    #1;
    check("reset_outputs", 64'({mon.err, mon.err_sticky, mon.chk_cnt, mon.err_cnt,
                                mon.first_exp, mon.first_obs, mon.busy}), 64'd0);

    // Matched chain: compared values 0x0E, 0x0E, 0x02, 0xFE.
    drive(1, 0, 8'h33, 0, 0);
    drive(1, 0, 8'h05, 0, 0);
    drive(1, 0, 8'h06, 0, 0);
    drive(1, 0, 8'hFF, 0, 0);
    drive(1, 0, 8'hFE, 0, 0);
    drive(1, 0, rnd8(), 0, 0);
    drive(0, 0, rnd8(), 0, 0);
    drive(0, 0, rnd8(), 0, 0);
    check("matched_chk_cnt", 64'(mon.chk_cnt), 64'd4);
    check("matched_err_cnt", 64'(mon.err_cnt), 64'd0);
    for (int k = 0; k < 4; k++) drive(0, 0, rnd8(), 2, 0);
    check("idle_no_count", 64'(mon.chk_cnt), 64'd4);

    // Injected error on i = 0x05, then a second mismatch.
    drive(1, 0, rnd8(), 0, 0);
    drive(1, 0, 8'h05, 0, 0);
    drive(1, 0, rnd8(), 0, 0);
    drive(1, 0, rnd8(), 1, 8'h0F);
    drive(1, 0, rnd8(), 2, 0);
    drive(0, 0, rnd8(), 0, 0);
    drive(0, 0, rnd8(), 0, 0);
    check("inject_sticky", 64'(mon.err_sticky), 64'd1);
    check("inject_err_cnt", 64'(mon.err_cnt), 64'd2);
    check("inject_first_exp", 64'(mon.first_exp), 64'h0E);
    check("inject_first_obs", 64'(mon.first_obs), 64'h0F);

    // Enable toggle 1 -> 0 -> 1 with mismatching o during idle/priming.
    drive(1, 0, rnd8(), 2, 0);
    drive(1, 0, rnd8(), 2, 0);
    drive(0, 0, rnd8(), 2, 0);
    for (int k = 0; k < 6; k++) drive(1, 0, rnd8(), 0, 0);

    // Clear colliding with a mismatching comparison.
    drive(1, 1, rnd8(), 2, 0);
    drive(0, 0, rnd8(), 0, 0);
    check("clr_err_cnt", 64'(mon.err_cnt), 64'd0);
    check("clr_sticky", 64'(mon.err_sticky), 64'd0);
    check("clr_first_exp", 64'(mon.first_exp), 64'd0);
    check("clr_chk_cnt", 64'(mon.chk_cnt), 64'd0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++)
      drive(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 39) == 0),
            rnd8(), ($urandom_range(0, 4) == 0) ? 2 : 0, 0);

    check("sat_chk_cnt", 64'(mon4.chk_cnt), 64'd15);
    check("sat_err_cnt", 64'(mon4.err_cnt), 64'd15);

    // Asynchronous reset mid-CHECK.
    for (int k = 0; k < 5; k++) drive(1, 0, rnd8(), 2, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", 64'({mon.err, mon.err_sticky, mon.chk_cnt, mon.err_cnt,
                                    mon.first_exp, mon.first_obs, mon.busy}), 64'd0);
    check("async_rst_outputs4", 64'({mon4.err, mon4.err_sticky, mon4.chk_cnt, mon4.err_cnt,
                                     mon4.busy}), 64'd0);
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) drive(0, 0, rnd8(), 2, 0);
    for (int k = 0; k < 6; k++) drive(1, 0, rnd8(), 0, 0);
    drive(0, 0, rnd8(), 0, 0);
    drive(0, 0, rnd8(), 0, 0);
    check("post_rst_chk_cnt", 64'(mon.chk_cnt), 64'd4);
    check("post_rst_err_cnt", 64'(mon.err_cnt), 64'd0);

    for (int k = 0; k < 25; k++) drive(logic'($urandom_range(0, 3) != 0), 0, rnd8(), 0, 0);
    check("sat_chk_cnt_final", 64'(mon4.chk_cnt), 64'd15);
    check("sat_err_cnt_final", 64'(mon4.err_cnt), 64'd15);
    check("sat_sticky", 64'(mon4.err_sticky), 64'd1);

    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
